// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   state_e   : fetch FSM state (RUN / FAULT / STOP)
//   entry_t   : one buffered fetch result {pc, inst}
//   ENTRY_W   : width of entry_t in bits
//   align_pc  : clears the two low address bits of a fetch target
package fetch_queue_pkg;

    localparam int unsigned ENTRY_W = 64;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FAULT = 2'd1,
        ST_STOP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory and decode.
// Handshakes: a request issues when imem_req && imem_ready; a response is
// one cycle of imem_valid, in issue order; decode pops when
// inst_valid && inst_ready. Valid never waits on ready.
//   master : the fetch queue's view (drives imem_req/addr and inst_*)
//   slave  : the environment's view (memory + decode + redirect/halt)
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_fault,
        input  imem_ready, imem_valid, imem_rdata, redirect, redirect_pc,
               halt, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_fault,
        output imem_ready, imem_valid, imem_rdata, redirect, redirect_pc,
               halt, inst_ready
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous circular buffer holding fetched {pc, inst} entries.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_push/i_data  : write one entry at the tail
//   i_pop          : advance the head
//   i_flush        : empty the buffer; wins over push and pop
//   o_full/o_empty : occupancy flags
//   o_count        : number of valid entries (0..DEPTH)
//   o_head         : entry at the head (undefined when empty)
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned WIDTH = ENTRY_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [WIDTH-1:0]           o_head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) wr_ptr_d = (wr_ptr_q + AW'(1)) & PTR_MASK;
            if (i_pop)  rd_ptr_d = (rd_ptr_q + AW'(1)) & PTR_MASK;
            count_d = count_q + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues fetches to a variable-latency memory,
// buffers responses and hands {pc, inst} to decode in program order.
// Redirects flush the buffer and drop responses still in flight.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : fetch_queue_if.master (imem request/response, redirect,
//                  halt, decode handshake)
//   o_dbg_state  : current FSM state
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH      = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fetch_queue_if.master bus,
    output state_e        o_dbg_state
);
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [31:0]   fault_pc_q, fault_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    entry_t        head, push_entry;
    logic          credit_ok, req, issue, resp, keep, pop;

    // Buffered plus in-flight never exceeds DEPTH, so every kept response
    // is guaranteed a free slot.
    always_comb begin
        credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight_q}) < DEPTH_C;
        req        = !i_rst && (state_q == ST_RUN) && !bus.redirect &&
                     !bus.halt && credit_ok;
        issue      = req && bus.imem_ready;
        resp       = bus.imem_valid;
        keep       = resp && !bus.redirect && (discard_q == '0);
        pop        = !bus.redirect && (state_q != ST_FAULT) && !fifo_empty &&
                     bus.inst_ready;
        push_entry = '{pc: resp_pc_q, inst: bus.imem_rdata};
    end

    fetch_queue_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (keep),
        .i_data  (push_entry),
        .i_pop   (pop),
        .i_flush (bus.redirect),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count),
        .o_head  (head)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_ADDR;
            resp_pc_q  <= RESET_ADDR;
            fault_pc_q <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            fault_pc_q <= fault_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    // Next-state logic; a redirect overrides everything else.
    always_comb begin
        state_d = state_q;
        if (bus.redirect) begin
            state_d = (bus.redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN:   if (bus.halt) state_d = ST_STOP;
                ST_FAULT: if (bus.inst_ready) state_d = ST_STOP;
                ST_STOP:  state_d = ST_STOP;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // PC and credit bookkeeping.
    always_comb begin
        inflight_d = inflight_q + CW'(issue) - CW'(resp);
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        fault_pc_d = fault_pc_q;
        discard_d  = discard_q;
        if (bus.redirect) begin
            // Every request still outstanding after this cycle is stale.
            // discard is a subset of inflight, so it is replaced, not added.
            discard_d  = inflight_q + CW'(issue) - CW'(resp);
            fetch_pc_d = align_pc(bus.redirect_pc);
            resp_pc_d  = align_pc(bus.redirect_pc);
            fault_pc_d = bus.redirect_pc;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
            if (keep)  resp_pc_d  = resp_pc_q + 32'd4;
            if (resp && (discard_q != '0)) discard_d = discard_q - CW'(1);
        end
    end

    // Outputs; data is forced to zero whenever no entry is presented.
    always_comb begin
        bus.imem_req  = req;
        bus.imem_addr = fetch_pc_q;
        o_dbg_state   = state_q;
        if (state_q == ST_FAULT) begin
            bus.inst_valid = 1'b1;
            bus.inst       = '0;
            bus.inst_pc    = fault_pc_q;
            bus.inst_fault = 1'b1;
        end else begin
            bus.inst_valid = !fifo_empty;
            bus.inst       = fifo_empty ? 32'h0 : head.inst;
            bus.inst_pc    = fifo_empty ? 32'h0 : head.pc;
            bus.inst_fault = 1'b0;
        end
    end

    no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(keep && fifo_full && !pop));
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_e dbg_state;
    always #5 clk = ~clk;

    fetch_queue_if bus();

    fetch_queue #(
        .RESET_ADDR (32'h0000_0000),
        .DEPTH      (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- memory model ----------------
    // Fixed-latency pipeline; data is a function of the address so both
    // pc and inst are checked independently.
    int          lat = 1;
    int          issue_cnt = 0;
    logic [3:0]  pv;
    logic [31:0] pa [4];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1300_0013;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pv        <= '0;
            issue_cnt <= 0;
        end else begin
            pv[0] <= bus.imem_req && bus.imem_ready;
            pa[0] <= bus.imem_addr;
            for (int i = 1; i < 4; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
            if (bus.imem_req && bus.imem_ready) issue_cnt <= issue_cnt + 1;
        end
    end

    assign bus.imem_valid = pv[lat-1];
    assign bus.imem_rdata = mem_data(pa[lat-1]);

    // ---------------- scoreboard ----------------
    logic [64:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int pops = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [64:0] ent(input logic [31:0] pc);
        return {1'b0, pc, mem_data(pc)};
    endfunction

    task automatic expect_seq(input logic [31:0] start, input int n);
        logic [31:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(ent(pc));
            pc = pc + 32'd4;
        end
    endtask

    // Monitor: a pop happens at the next edge when valid && ready and no redirect.
    always @(negedge clk) begin
        if (!rst && bus.inst_valid && bus.inst_ready && !bus.redirect) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pop: got pc %h inst %h fault %b expected nothing",
                         bus.inst_pc, bus.inst, bus.inst_fault);
            end else begin
                check("pop_entry", {bus.inst_fault, bus.inst_pc, bus.inst}, exp_q.pop_front());
            end
            pops++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int latency);
        lat             = latency;
        rst             = 1'b1;
        bus.imem_ready  = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.halt        = 1'b0;
        bus.inst_ready  = 1'b0;
        repeat (3) step();
        check("rst_req", 65'(bus.imem_req), 65'(0));
        check("rst_outputs", {bus.inst_valid, bus.inst_fault, bus.inst, bus.inst_pc},
              65'(0));
        check("rst_addr_state", {bus.imem_addr, 31'(dbg_state)}, {32'h0, 31'(ST_RUN)});
        rst = 1'b0;
    endtask

    task automatic consume(input string name, input int n, input int bound);
        int target;
        int cyc;
        target         = pops + n;
        cyc            = 0;
        bus.inst_ready = 1'b1;
        while (pops < target && cyc < bound) begin
            step();
            cyc++;
        end
        bus.inst_ready = 1'b0;
        check(name, 65'(pops), 65'(target));
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        #1;
        check("redirect_no_req", 65'(bus.imem_req), 65'(0));
        step();
        bus.redirect = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int ic;

        // 1: streaming, 1-cycle memory, decode always ready
        do_reset(1);
        bus.inst_ready = 1'b1;
        expect_seq(32'h0, 8);
        step();
        check("fill_cycle1_invalid", 65'(bus.inst_valid), 65'(0));
        step();
        check("fill_cycle2_valid", 65'(bus.inst_valid), 65'(1));
        cyc = 2;
        while (pops < 8 && cyc < 40) begin
            step();
            cyc++;
        end
        bus.inst_ready = 1'b0;
        check("stream_cycles", 65'(cyc), 65'(10));
        check("stream_empty_q", 65'(exp_q.size()), 65'(0));

        // 2: decode stalled for 20 cycles, then drained
        do_reset(1);
        repeat (20) step();
        check("stall_issues", 65'(issue_cnt), 65'(4));
        check("stall_req_low", 65'(bus.imem_req), 65'(0));
        check("stall_head", {bus.inst_valid, bus.inst_pc}, {1'b1, 32'h0});
        expect_seq(32'h0, 12);
        consume("stall_drain", 12, 60);
        check("stall_empty_q", 65'(exp_q.size()), 65'(0));

        // 3: 3-cycle memory, redirect with 3 in flight (one returning now)
        do_reset(3);
        bus.inst_ready = 1'b1;
        repeat (3) step();
        check("lat3_issued", 65'(issue_cnt), 65'(3));
        redirect_to(32'h0000_0100);
        expect_seq(32'h0000_0100, 4);
        consume("lat3_redirect", 4, 40);
        check("lat3_empty_q", 65'(exp_q.size()), 65'(0));

        // 4: misaligned redirect -> single fault entry, then idle
        do_reset(1);
        repeat (8) step();
        redirect_to(32'h0000_0102);
        check("fault_state", 65'(dbg_state), 65'(ST_FAULT));
        ic = issue_cnt;
        exp_q.push_back({1'b1, 32'h0000_0102, 32'h0});
        repeat (3) step();
        check("fault_no_issue", 65'(issue_cnt), 65'(ic));
        consume("fault_pop", 1, 10);
        repeat (4) step();
        check("fault_after_pop", {bus.inst_valid, 32'(dbg_state)}, {1'b0, 32'(ST_STOP)});
        check("fault_still_no_issue", 65'(issue_cnt), 65'(ic));
        redirect_to(32'h0000_0040);
        expect_seq(32'h0000_0040, 2);
        consume("fault_resume", 2, 20);

        // 5: halt pulse, drain in-flight, resume on redirect
        do_reset(3);
        repeat (2) step();
        bus.halt = 1'b1;
        #1;
        check("halt_req_low", 65'(bus.imem_req), 65'(0));
        step();
        bus.halt = 1'b0;
        check("halt_state", 65'(dbg_state), 65'(ST_STOP));
        repeat (6) step();
        check("halt_issues", 65'(issue_cnt), 65'(2));
        expect_seq(32'h0, 2);
        consume("halt_drain", 2, 20);
        repeat (3) step();
        check("halt_idle", 65'(bus.inst_valid), 65'(0));
        redirect_to(32'h0000_0040);
        expect_seq(32'h0000_0040, 3);
        consume("halt_resume", 3, 30);

        // 6: response in the redirect cycle is dropped; PC wraps past 2^32
        do_reset(1);
        step();
        redirect_to(32'hFFFF_FFF8);
        expect_seq(32'hFFFF_FFF8, 4);
        consume("wrap", 4, 20);
        check("wrap_empty_q", 65'(exp_q.size()), 65'(0));

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end
endmodule
